// File: rtl/cv32e40p_hwloop_pkg.sv
// Shared types and constants for the hardware-loop context register file.
package cv32e40p_hwloop_pkg;

  localparam int unsigned HWLP_MAX_LOOPS = 4;

  typedef enum logic [1:0] {
    HWLP_RD_START  = 2'd0,
    HWLP_RD_END    = 2'd1,
    HWLP_RD_COUNT  = 2'd2,
    HWLP_RD_STATUS = 2'd3
  } hwlp_rd_sel_e;

  localparam int unsigned HWLP_STATUS_ACTIVE_BIT = 0;
  localparam int unsigned HWLP_STATUS_LAST_BIT   = 1;
  localparam int unsigned HWLP_STATUS_ERR_BIT    = 2;

  // Halfword mode clears bit 0, word mode clears bits [1:0].
  function automatic logic [31:0] hwlp_align(input logic [31:0] addr, input logic halfword);
    return halfword ? {addr[31:1], 1'b0} : {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cv32e40p_hwloop_cnt.sv
// One loop counter: load with width check, saturating decrement, registered active/last flags.
module cv32e40p_hwloop_cnt
  import cv32e40p_hwloop_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [31:0]          load_data_i,
  input  logic                 dec_i,
  output logic [CNT_WIDTH-1:0] counter_o,
  output logic                 active_o,
  output logic                 last_o,
  output logic                 ovf_o,
  output logic                 udf_o
);

  // Bits of the write data that do not fit into the counter; zero when CNT_WIDTH is 32.
  localparam logic [31:0] HI_MASK = ~(32'hFFFF_FFFF >> (32 - CNT_WIDTH));

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 active_q, last_q;
  logic                 load_ovf, cnt_zero;

  always_comb begin
    load_ovf = |(load_data_i & HI_MASK);
    cnt_zero = (cnt_q == '0);
    cnt_d    = cnt_q;
    if (load_i) begin
      cnt_d = load_ovf ? '1 : load_data_i[CNT_WIDTH-1:0];
    end else if (dec_i && !cnt_zero) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
    ovf_o = load_i & load_ovf;
    udf_o = dec_i & ~load_i & cnt_zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= (cnt_d != '0);
      last_q   <= (cnt_d == CNT_WIDTH'(1));
    end
  end

  assign counter_o = cnt_q;
  assign active_o  = active_q;
  assign last_o    = last_q;

endmodule

// File: rtl/cv32e40p_hwloop_ctx.sv
// Hardware-loop context register file: START/END/COUNT per loop, sticky error, registered read port.
module cv32e40p_hwloop_ctx
  import cv32e40p_hwloop_pkg::*;
#(
  parameter int unsigned N_LOOPS   = 2,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned C_ALIGN   = 1,
  parameter int unsigned ID_W      = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [2:0]                          we_i,
  input  logic                                setup_i,
  input  logic [ID_W-1:0]                     regid_i,
  input  logic [31:0]                         start_data_i,
  input  logic [31:0]                         end_data_i,
  input  logic [31:0]                         cnt_data_i,
  input  logic                                valid_i,
  input  logic [N_LOOPS-1:0]                  dec_cnt_i,
  input  logic                                err_clr_i,
  input  logic [ID_W-1:0]                     rd_regid_i,
  input  logic [1:0]                          rd_sel_i,
  output logic [N_LOOPS-1:0][31:0]            start_addr_o,
  output logic [N_LOOPS-1:0][31:0]            end_addr_o,
  output logic [N_LOOPS-1:0][CNT_WIDTH-1:0]   counter_o,
  output logic [N_LOOPS-1:0]                  active_o,
  output logic [N_LOOPS-1:0]                  last_o,
  output logic                                err_o,
  output logic [31:0]                         rd_data_o
);

  logic [2:0]                        we_eff;
  logic [N_LOOPS-1:0]                wr_start, wr_end, wr_cnt, wr_any;
  logic [N_LOOPS-1:0]                dec_eff, ovf, udf;
  logic                              multi_dec, err_set;
  logic [N_LOOPS-1:0][31:0]          start_q, end_q;
  logic [N_LOOPS-1:0][CNT_WIDTH-1:0] cnt;
  logic [N_LOOPS-1:0]                active, last;
  logic                              err_q;
  logic [31:0]                       rd_d, rd_q;

  always_comb begin
    we_eff = we_i | {3{setup_i}};
    for (int unsigned k = 0; k < N_LOOPS; k++) begin
      wr_start[k] = we_eff[0] && (regid_i == ID_W'(k));
      wr_end[k]   = we_eff[1] && (regid_i == ID_W'(k));
      wr_cnt[k]   = we_eff[2] && (regid_i == ID_W'(k));
    end
    wr_any = wr_start | wr_end | wr_cnt;
    // A write to a loop swallows its decrement, so it counts neither for underflow nor multi-decrement.
    dec_eff   = (valid_i ? dec_cnt_i : '0) & ~wr_any;
    multi_dec = (dec_eff & (dec_eff - N_LOOPS'(1))) != '0;
    err_set   = (|ovf) | (|udf) | multi_dec;
  end

  for (genvar k = 0; k < N_LOOPS; k++) begin : g_loop
    cv32e40p_hwloop_cnt #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (wr_cnt[k]),
      .load_data_i (cnt_data_i),
      .dec_i       (dec_eff[k]),
      .counter_o   (cnt[k]),
      .active_o    (active[k]),
      .last_o      (last[k]),
      .ovf_o       (ovf[k]),
      .udf_o       (udf[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      end_q   <= '0;
    end else begin
      for (int unsigned k = 0; k < N_LOOPS; k++) begin
        if (wr_start[k]) start_q[k] <= hwlp_align(start_data_i, C_ALIGN != 0);
        if (wr_end[k])   end_q[k]   <= hwlp_align(end_data_i, C_ALIGN != 0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end else if (err_clr_i) begin
      err_q <= 1'b0;
    end
  end

  always_comb begin
    rd_d = '0;
    for (int unsigned k = 0; k < N_LOOPS; k++) begin
      if (rd_regid_i == ID_W'(k)) begin
        case (hwlp_rd_sel_e'(rd_sel_i))
          HWLP_RD_START: rd_d = start_q[k];
          HWLP_RD_END:   rd_d = end_q[k];
          HWLP_RD_COUNT: rd_d = 32'(cnt[k]);
          HWLP_RD_STATUS: begin
            rd_d[HWLP_STATUS_ERR_BIT]    = err_q;
            rd_d[HWLP_STATUS_LAST_BIT]   = last[k];
            rd_d[HWLP_STATUS_ACTIVE_BIT] = active[k];
          end
          default: rd_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= rd_d;
  end

  assign start_addr_o = start_q;
  assign end_addr_o   = end_q;
  assign counter_o    = cnt;
  assign active_o     = active;
  assign last_o       = last;
  assign err_o        = err_q;
  assign rd_data_o    = rd_q;

endmodule

// File: tb/tb_cv32e40p_hwloop_ctx.sv
// Directed table-driven bench for cv32e40p_hwloop_ctx (2 loops, 16-bit counters, halfword alignment).
module tb_cv32e40p_hwloop_ctx;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       we_i;
  logic             setup_i;
  logic [1:0]       regid_i;
  logic [31:0]      start_data_i, end_data_i, cnt_data_i;
  logic             valid_i;
  logic [1:0]       dec_cnt_i;
  logic             err_clr_i;
  logic [1:0]       rd_regid_i;
  logic [1:0]       rd_sel_i;
  logic [1:0][31:0] start_addr_o, end_addr_o;
  logic [1:0][15:0] counter_o;
  logic [1:0]       active_o, last_o;
  logic             err_o;
  logic [31:0]      rd_data_o;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  cv32e40p_hwloop_ctx #(
    .N_LOOPS   (2),
    .CNT_WIDTH (16),
    .C_ALIGN   (1),
    .ID_W      (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .we_i         (we_i),
    .setup_i      (setup_i),
    .regid_i      (regid_i),
    .start_data_i (start_data_i),
    .end_data_i   (end_data_i),
    .cnt_data_i   (cnt_data_i),
    .valid_i      (valid_i),
    .dec_cnt_i    (dec_cnt_i),
    .err_clr_i    (err_clr_i),
    .rd_regid_i   (rd_regid_i),
    .rd_sel_i     (rd_sel_i),
    .start_addr_o (start_addr_o),
    .end_addr_o   (end_addr_o),
    .counter_o    (counter_o),
    .active_o     (active_o),
    .last_o       (last_o),
    .err_o        (err_o),
    .rd_data_o    (rd_data_o)
  );

  typedef struct {
    logic [2:0]  we;
    logic        setup;
    logic [1:0]  regid;
    logic [31:0] start_d, end_d, cnt_d;
    logic        valid;
    logic [1:0]  dec;
    logic        clr;
    logic [1:0]  rd_id, rd_sel;
    logic [15:0] e_cnt0, e_cnt1;
    logic [1:0]  e_act, e_last;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] we, input logic setup, input logic [1:0] regid,
                     input logic [31:0] sd, input logic [31:0] ed, input logic [31:0] cd,
                     input logic valid, input logic [1:0] dec, input logic clr,
                     input logic [1:0] rid, input logic [1:0] rsel,
                     input logic [15:0] c0, input logic [15:0] c1, input logic [1:0] act,
                     input logic [1:0] lst, input logic err, input logic [31:0] rd);
    vec_t v;
    v.we = we; v.setup = setup; v.regid = regid;
    v.start_d = sd; v.end_d = ed; v.cnt_d = cd;
    v.valid = valid; v.dec = dec; v.clr = clr; v.rd_id = rid; v.rd_sel = rsel;
    v.e_cnt0 = c0; v.e_cnt1 = c1; v.e_act = act; v.e_last = lst; v.e_err = err; v.e_rd = rd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    we_i = '0; setup_i = 1'b0; regid_i = '0;
    start_data_i = '0; end_data_i = '0; cnt_data_i = '0;
    valid_i = 1'b0; dec_cnt_i = '0; err_clr_i = 1'b0;
    rd_regid_i = '0; rd_sel_i = '0;
  endtask

  initial begin
    // rd_sel: 0=START 1=END 2=COUNT 3=STATUS (rd expectation is the pre-edge value)
    //   we   set rid start         end           cnt           vld dec  clr rid rsel  cnt0      cnt1      act    last   err rd
    add(3'b000,1,1, 32'h103,      32'h1FE,      32'd3,        0, 2'b00,0, 0, 0,   16'h0,    16'h3,    2'b10, 2'b00, 0, 32'h0);
    add(3'b000,0,0, 32'h0,        32'h0,        32'h0,        1, 2'b10,0, 1, 0,   16'h0,    16'h2,    2'b10, 2'b00, 0, 32'h102);
    add(3'b000,0,0, 32'h0,        32'h0,        32'h0,        1, 2'b10,0, 1, 1,   16'h0,    16'h1,    2'b10, 2'b10, 0, 32'h1FE);
    add(3'b000,0,0, 32'h0,        32'h0,        32'h0,        1, 2'b10,0, 1, 3,   16'h0,    16'h0,    2'b00, 2'b00, 0, 32'h3);
    add(3'b000,0,0, 32'h0,        32'h0,        32'h0,        1, 2'b10,0, 1, 2,   16'h0,    16'h0,    2'b00, 2'b00, 1, 32'h0);
    add(3'b000,0,0, 32'h0,        32'h0,        32'h0,        0, 2'b00,1, 1, 3,   16'h0,    16'h0,    2'b00, 2'b00, 0, 32'h4);
    add(3'b100,0,1, 32'h0,        32'h0,        32'd4,        0, 2'b00,0, 1, 2,   16'h0,    16'h4,    2'b10, 2'b00, 0, 32'h0);
    add(3'b100,0,0, 32'h0,        32'h0,        32'd5,        1, 2'b11,0, 0, 2,   16'h5,    16'h3,    2'b11, 2'b00, 0, 32'h0);
    add(3'b000,0,0, 32'h0,        32'h0,        32'h0,        1, 2'b11,0, 1, 2,   16'h4,    16'h2,    2'b11, 2'b00, 1, 32'h3);
    add(3'b000,0,0, 32'h0,        32'h0,        32'h0,        0, 2'b11,0, 0, 3,   16'h4,    16'h2,    2'b11, 2'b00, 1, 32'h5);
    add(3'b000,0,0, 32'h0,        32'h0,        32'h0,        0, 2'b00,1, 3, 2,   16'h4,    16'h2,    2'b11, 2'b00, 0, 32'h0);
    add(3'b100,0,0, 32'h0,        32'h0,        32'h0001_0000,0, 2'b00,0, 0, 2,   16'hFFFF, 16'h2,    2'b11, 2'b00, 1, 32'h4);
    add(3'b100,0,1, 32'h0,        32'h0,        32'h0002_0000,0, 2'b00,1, 0, 2,   16'hFFFF, 16'hFFFF, 2'b11, 2'b00, 1, 32'hFFFF);
    add(3'b000,0,0, 32'h0,        32'h0,        32'h0,        0, 2'b00,1, 1, 2,   16'hFFFF, 16'hFFFF, 2'b11, 2'b00, 0, 32'hFFFF);
    add(3'b100,0,0, 32'h0,        32'h0,        32'd1,        0, 2'b00,0, 0, 2,   16'h1,    16'hFFFF, 2'b11, 2'b01, 0, 32'hFFFF);
    add(3'b000,0,0, 32'h0,        32'h0,        32'h0,        0, 2'b00,0, 0, 3,   16'h1,    16'hFFFF, 2'b11, 2'b01, 0, 32'h3);
    add(3'b100,0,0, 32'h0,        32'h0,        32'd0,        0, 2'b00,0, 0, 2,   16'h0,    16'hFFFF, 2'b10, 2'b00, 0, 32'h1);
    add(3'b100,0,0, 32'h0,        32'h0,        32'd7,        1, 2'b01,0, 1, 3,   16'h7,    16'hFFFF, 2'b11, 2'b00, 0, 32'h1);
    add(3'b001,0,0, 32'h2003,     32'h0,        32'h0,        0, 2'b00,0, 0, 0,   16'h7,    16'hFFFF, 2'b11, 2'b00, 0, 32'h0);
    add(3'b010,0,0, 32'h0,        32'h3001,     32'h0,        0, 2'b00,0, 0, 0,   16'h7,    16'hFFFF, 2'b11, 2'b00, 0, 32'h2002);
    add(3'b000,0,0, 32'h0,        32'h0,        32'h0,        0, 2'b00,0, 0, 1,   16'h7,    16'hFFFF, 2'b11, 2'b00, 0, 32'h3000);
    add(3'b000,1,2, 32'h5,        32'h5,        32'd9,        0, 2'b00,0, 1, 2,   16'h7,    16'hFFFF, 2'b11, 2'b00, 0, 32'hFFFF);
    add(3'b000,0,0, 32'h0,        32'h0,        32'h0,        0, 2'b00,0, 0, 0,   16'h7,    16'hFFFF, 2'b11, 2'b00, 0, 32'h2002);

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst cnt",    32'(counter_o), 32'h0);
    chk("rst start0", start_addr_o[0], 32'h0);
    chk("rst start1", start_addr_o[1], 32'h0);
    chk("rst end0",   end_addr_o[0], 32'h0);
    chk("rst end1",   end_addr_o[1], 32'h0);
    chk("rst flags",  {27'h0, err_o, last_o, active_o}, 32'h0);
    chk("rst rd",     rd_data_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      we_i = vecs[i].we; setup_i = vecs[i].setup; regid_i = vecs[i].regid;
      start_data_i = vecs[i].start_d; end_data_i = vecs[i].end_d; cnt_data_i = vecs[i].cnt_d;
      valid_i = vecs[i].valid; dec_cnt_i = vecs[i].dec; err_clr_i = vecs[i].clr;
      rd_regid_i = vecs[i].rd_id; rd_sel_i = vecs[i].rd_sel;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d cnt0", i), 32'(counter_o[0]), 32'(vecs[i].e_cnt0));
      chk($sformatf("v%0d cnt1", i), 32'(counter_o[1]), 32'(vecs[i].e_cnt1));
      chk($sformatf("v%0d active", i), 32'(active_o), 32'(vecs[i].e_act));
      chk($sformatf("v%0d last", i), 32'(last_o), 32'(vecs[i].e_last));
      chk($sformatf("v%0d err", i), 32'(err_o), 32'(vecs[i].e_err));
      chk($sformatf("v%0d rd", i), rd_data_o, vecs[i].e_rd);
    end

    chk("addr start0", start_addr_o[0], 32'h2002);
    chk("addr end0",   end_addr_o[0], 32'h3000);
    chk("addr start1", start_addr_o[1], 32'h102);
    chk("addr end1",   end_addr_o[1], 32'h1FE);

    // Reset in the middle of a read clears rd_data_o without waiting for a clock.
    @(negedge clk);
    idle();
    rd_regid_i = 2'd0; rd_sel_i = 2'd2;
    @(posedge clk);
    #1;
    chk("midrst rd before", rd_data_o, 32'h7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst rd",    rd_data_o, 32'h0);
    chk("midrst cnt",   32'(counter_o), 32'h0);
    chk("midrst flags", {27'h0, err_o, last_o, active_o}, 32'h0);
    chk("midrst start", start_addr_o[0], 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    setup_i = 1'b1; regid_i = 2'd0;
    start_data_i = 32'h11; end_data_i = 32'h21; cnt_data_i = 32'd2;
    @(posedge clk);
    #1;
    chk("post-rst cnt0",   32'(counter_o[0]), 32'h2);
    chk("post-rst start0", start_addr_o[0], 32'h10);
    chk("post-rst end0",   end_addr_o[0], 32'h20);
    chk("post-rst active", 32'(active_o), 32'h1);
    @(negedge clk);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_hwloop_ctx.md
# cv32e40p_hwloop_ctx

Parametrised hardware-loop context register file for the PULP zero-overhead loop extension. It holds START, END and COUNT for N_LOOPS loops and supports a configurable counter width. It adds an atomic single-cycle setup, a saturating decrement, and registered active/last-iteration flags for the loop controller. It also provides a sticky error flag and a registered CSR read port. The block sits between the EX-stage CSR/setup path and the IF/ID hardware-loop controller.

## Interface
- N_LOOPS, 2: number of loop contexts; legal range 1..4.
- CNT_WIDTH, 32: counter width; legal range 8..32.
- C_ALIGN, 1: 1 = addresses are halfword-aligned (bit 0 cleared); 0 = addresses are word-aligned (bits [1:0] cleared).
- ID_W, $clog2(N_LOOPS) (minimum 1): loop selector width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- we_i  in  3  single-field writes: [0]=start, [1]=end, [2]=count
- setup_i  in  1  atomic write of start, end and count
- regid_i  in  ID_W  target loop for we_i/setup_i
- start_data_i, end_data_i, cnt_data_i  in  32 each  write data
- valid_i  in  1  instruction valid; gates decrement
- dec_cnt_i  in  N_LOOPS  decrement request, expected one-hot or zero
- err_clr_i  in  1  clears err_o
- rd_regid_i  in  ID_W  read loop select
- rd_sel_i  in  2  read field: START/END/COUNT/STATUS
- start_addr_o, end_addr_o  out  N_LOOPS×32  stored addresses
- counter_o  out  N_LOOPS×CNT_WIDTH  stored counters
- active_o  out  N_LOOPS  counter != 0
- last_o  out  N_LOOPS  counter == 1
- err_o  out  1  sticky error
- rd_data_o  out  32  registered read data

## Operation
- **Reset:** all start, end and counter registers are 0. active_o, last_o, err_o and rd_data_o are 0.
- **Address writes:** the data is aligned per C_ALIGN, then stored.
- **setup_i:** equivalent to we_i=3'b111 in the same cycle. setup_i OR-combines with we_i.
- **Count write:** if cnt_data_i[31:CNT_WIDTH] != 0, the counter loads all-ones and err_o sets. Otherwise the counter loads the low CNT_WIDTH bits.
- **Decrement:** occurs when valid_i & dec_cnt_i[k]. If counter > 0, counter is decremented by 1. If counter == 0, the counter stays 0 and err_o sets (underflow).
- **Priority per loop:** a write to loop k beats a decrement of loop k. The decrement is dropped and no error is raised. A write to loop j and a decrement of loop k≠j both take effect.
- **Multiple decrements:** valid_i with more than one dec_cnt_i bit set sets err_o. All requested loops still decrement.
- **active_o / last_o:** registered flags, updated in the same edge as the counter from its next value. There is no combinational compare on the output path.
- **err_o:** sticky. err_clr_i clears it. If a set condition and err_clr_i occur in the same cycle, set wins.
- **Read port:**
  - START, END and COUNT return the stored value, with COUNT zero-extended.
  - STATUS returns {29'b0, err_o, last, active} for the selected loop.
  - A regid ≥ N_LOOPS returns 0.

## Timing
- All writes and decrements become visible on the outputs one cycle after the enabling edge.
- rd_data_o has 1-cycle latency. It samples the register values before any same-edge update (old data).
- If reset is asserted mid-operation, all state clears asynchronously. The first write is accepted on the first edge after deassertion.
- Counter wrap below 0 is impossible because the decrement saturates.

## Structure
- **cv32e40p_hwloop_pkg:**
  - hwlp_rd_sel_e (START=0, END=1, COUNT=2, STATUS=3)
  - HWLP_MAX_LOOPS=4
  - STATUS bit-position constants
- **Sub-module cv32e40p_hwloop_cnt:** one instance per loop. It contains the counter register, the load/decrement/saturation logic, the active/last flags, and underflow/overflow error pulses. The top level ORs these pulses into err_o.

## Test plan
- **Reset and setup:** after reset, all outputs are 0. setup_i with regid=1, start=0x103, end=0x1FE, cnt=3 and C_ALIGN=1 gives start 0x102, end 0x1FE, counter 3, active 1, last 0.
- **Count down:** three cycles of valid_i & dec_cnt_i=2'b10 give counter 2, then 1 (last_o[1]=1), then 0 (active 0, last 0). A fourth decrement leaves counter 0 and sets err_o=1.
- **Collision:** in the same cycle, write count=5 to loop 0, decrement loop 0, and decrement loop 1 (counter 4). Result: loop 0 counter 5, loop 1 counter 3, err_o 0.
- **Width check:** with CNT_WIDTH=16, cnt_data_i=0x0001_0000 gives counter 0xFFFF and err_o=1. Then err_clr_i gives err_o=0.
- **Multi-decrement:** valid_i with dec_cnt_i=2'b11 sets err_o and decrements both counters. The same dec_cnt_i with valid_i=0 causes no change.
- **Read port:**
  - rd_sel=STATUS on loop 0 with counter 1 returns 0x3 one cycle later.
  - rd_regid=3 with N_LOOPS=2 returns 0.
  - Asserting reset mid-read gives rd_data_o=0 immediately.
